// File: rtl/inst_mem_resp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : inst_mem_resp                                                  |
// | Desc    : Single-cycle instruction memory responder with program-load    |
// |           port; optional post-reset NOP sweep via INST_MEM_CLEAR_EN.     |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module inst_mem_resp #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] addr,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        fetch_err,
    output logic        ready,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic        ld_err,
    output logic [15:0] fetch_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0] mem [0:DEPTH-1];

    logic                  run;
    logic [ADDR_WIDTH-1:0] fetch_idx;
    logic                  fetch_go;
    logic                  fetch_bad;
    logic [ADDR_WIDTH-1:0] ld_idx;
    logic                  ld_go;
    logic                  ld_bad;
    logic                  ld_ok;
    logic                  collide;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [31:0]           mem_wdata;

    assign run       = (state == ST_RUN);
    assign ready     = run;

    assign fetch_idx = addr[ADDR_WIDTH+1:2];
    assign fetch_bad = (|addr[1:0]) || (|addr[31:ADDR_WIDTH+2]);
    assign fetch_go  = ce && run;

    assign ld_idx    = ld_addr[ADDR_WIDTH+1:2];
    assign ld_bad    = (|ld_addr[1:0]) || (|ld_addr[31:ADDR_WIDTH+2]);
    assign ld_go     = ld_en && run;
    assign ld_ok     = ld_go && !ld_bad;

    // Same-word load and fetch in one cycle returns the new data (write-first).
    assign collide   = ld_ok && (ld_idx == fetch_idx);

`ifdef INST_MEM_CLEAR_EN
    logic [ADDR_WIDTH-1:0] sweep_idx;
    logic                  sweep_last;

    assign sweep_last = (sweep_idx == {ADDR_WIDTH{1'b1}});

    always_ff @(posedge clk) begin
        if (!rst) begin
            sweep_idx <= '0;
        end else if (state == ST_CLEAR) begin
            sweep_idx <= sweep_idx + ADDR_WIDTH'(1);
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ld_idx;
        mem_wdata = ld_data;
        if (rst) begin
            if (state == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = sweep_idx;
                mem_wdata = NOP_INST;
            end else if (ld_ok) begin
                mem_we    = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (sweep_last) state_nxt = ST_RUN;
            ST_RUN:   state_nxt = ST_RUN;
            default:  state_nxt = ST_CLEAR;
        endcase
    end
`else
    always_comb begin
        mem_we    = rst && ld_ok;
        mem_waddr = ld_idx;
        mem_wdata = ld_data;
    end

    // Without the sweep, CLEAR is a single not-ready cycle after reset.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: state_nxt = ST_RUN;
            ST_RUN:   state_nxt = ST_RUN;
            default:  state_nxt = ST_CLEAR;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
            fetch_err  <= 1'b0;
            ld_err     <= 1'b0;
            fetch_cnt  <= 16'h0000;
        end else begin
            ld_err <= ld_go && ld_bad;
            if (fetch_go) begin
                inst_valid <= 1'b1;
                fetch_err  <= fetch_bad;
                fetch_cnt  <= fetch_cnt + 16'd1;
                if (fetch_bad) begin
                    inst <= NOP_INST;
                end else if (collide) begin
                    inst <= ld_data;
                end else begin
                    inst <= mem[fetch_idx];
                end
            end else begin
                inst       <= NOP_INST;
                inst_valid <= 1'b0;
                fetch_err  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/inst_mem_resp.md
# inst_mem_resp

Instruction-memory responder at the far end of the fetch interface. It accepts a word address and chip enable from the PC register and returns the addressed 32-bit instruction one cycle later. It also provides a program-load write port for testbenches and the boot loader, and after reset it can optionally sweep the whole array to NOP. It sits between the PC register and the IF/ID pipeline register.

## Interface
Parameters:
- ADDR_WIDTH, 10: word-address bits; the array holds 2^ADDR_WIDTH words (default 4 KiB).
- NOP_INST, 32'h00000013: the instruction returned when no valid fetch is served (addi x0,x0,0).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-low.
- ce  in  1  fetch enable from the PC register; 1 = fetch requested.
- addr  in  32  byte address of the instruction.
- inst  out  32  returned instruction.
- inst_valid  out  1  high for exactly the cycle in which `inst` is the response to a served fetch.
- fetch_err  out  1  high together with inst_valid when the served fetch was misaligned or out of range.
- ready  out  1  1 = in RUN state and able to serve fetches and loads.
- ld_en  in  1  load-port write strobe.
- ld_addr  in  32  load byte address.
- ld_data  in  32  load data.
- ld_err  out  1  one-cycle pulse when a load is rejected.
- fetch_cnt  out  16  count of served fetches; wraps.

## Operation
- FSM with two states, CLEAR and RUN. Reset (rst=0 at a rising edge) enters CLEAR with the sweep index at 0. In CLEAR there is no reset-enable behaviour (see Configuration).
- CLEAR: one word per cycle is written with NOP_INST, at index 0 up to 2^ADDR_WIDTH-1. The state moves to RUN on the cycle after the last word is written. In CLEAR, ready=0, fetches are not served (inst=NOP_INST, inst_valid=0) and ld_en is ignored with no ld_err.
- RUN: ready=1.
- Fetch: a fetch is served when ce=1 and the state is RUN.
  - The word index is addr[ADDR_WIDTH+1:2].
  - The fetch is misaligned if addr[1:0]!=0.
  - The fetch is out of range if addr[31:ADDR_WIDTH+2]!=0.
  - On a misaligned or out-of-range fetch: inst=NOP_INST, inst_valid=1, fetch_err=1. The array is not read.
- Idle: when ce=0, inst=NOP_INST, inst_valid=0 and fetch_err=0. This is a NOP bubble, not a hold of the last value.
- Load: when ld_en=1 in RUN, the word index is ld_addr[ADDR_WIDTH+1:2].
  - A misaligned or out-of-range load is dropped, and ld_err pulses for 1 cycle on the next cycle.
  - Otherwise the word is written at the edge.
- Collision: a load and a fetch to the same word in the same cycle resolve write-first, so the fetch returns ld_data.
- fetch_cnt increments by 1 per served fetch, error fetches included, and wraps from 16'hFFFF to 16'h0000.

## Timing
- Reset values: inst=NOP_INST, inst_valid=0, fetch_err=0, ld_err=0, ready=0, fetch_cnt=0, state=CLEAR, sweep index=0. Array contents are not reset.
- Read latency is 1 cycle. ce/addr are sampled at edge N, and inst, inst_valid and fetch_err are valid after edge N and held until edge N+1.
- A new fetch can be accepted every cycle. There is no back-pressure other than ready.
- Load-to-fetch: a load at edge N is visible to a fetch sampled at edge N, by write-first.
- CLEAR lasts exactly 2^ADDR_WIDTH cycles; ready rises after edge 2^ADDR_WIDTH following the release of rst.
- rst=0 during CLEAR restarts the sweep at index 0.
- rst=0 during RUN forces all outputs to their reset values on the next edge. A fetch sampled at that edge is discarded.

## Configuration
- INST_MEM_CLEAR_EN defined: the CLEAR sweep is compiled in as described above.
- INST_MEM_CLEAR_EN undefined:
  - Reset goes directly to RUN, and ready=1 on the first edge with rst=1.
  - Array contents are left unchanged across reset.
  - No sweep logic or index counter is generated.
  - All other behaviour is identical.

## Test plan
- Reset, then clear: hold rst=0 for 2 cycles, release, keep ce=1, addr=0.
  - ready rises after exactly 1024 cycles.
  - The first served fetch returns 32'h00000013 with inst_valid=1 and fetch_cnt=1.
- Load then fetch: load 32'h00500093 at 0x4, then fetch 0x4 the next cycle → inst=32'h00500093 one cycle later.
- Back-to-back fetch: fetch 0x0, 0x4, 0x8 on consecutive cycles → three consecutive valid responses in order, each one cycle after its address.
- Error cases:
  - Fetch 0x2 → NOP with fetch_err=1.
  - Fetch 0x1000 → NOP with fetch_err=1.
  - Load to 0x1000 → ld_err pulse, and the array is unchanged.
- Collision: in the same cycle, ld_en with ld_addr=0x10, ld_data=0xDEADBEEF and fetch 0x10 → inst=0xDEADBEEF.
- Counter wrap and reset: preload fetch_cnt to 0xFFFF by 65535 fetches, then fetch once → fetch_cnt=0. Then assert rst mid-fetch → inst_valid=0 and ready=0 on the next edge.
